reg_load_arbiter: RTL and testbench
===================================

# reg_load_arbiter

Two-requester, round-robin load arbiter for a shared parallel-load D flip-flop data register. Each requester presents a word and a request; the block grants one requester per load and writes that requester's word into the owned register. It returns a one-cycle acknowledge to the winner and optionally enforces idle guard cycles between loads. It sits between independent producer blocks and the single storage register they share.

## Interface
- `WIDTH`, default 4: data/register width in bits.
- `GAP`, default 0: idle guard cycles after each load (0–15); no grants during the gap.
- `clk`  in  1: clock; all state changes on the rising edge.
- `clear`  in  1: asynchronous, active-high reset.
- `req0`  in  1: requester 0 load request; held high until `ack0` is seen.
- `d0`  in  WIDTH: requester 0 data; must be stable while `req0` is high.
- `req1`  in  1: requester 1 load request.
- `d1`  in  WIDTH: requester 1 data.
- `ack0`  out  1: one-cycle pulse; `d0` was written to `q` at the same edge.
- `ack1`  out  1: one-cycle pulse for requester 1.
- `q`  out  WIDTH: shared register contents.
- `busy`  out  1: high while in GAP state (decoded from the state register).
- `last_owner`  out  1: index of the requester that performed the latest load (only with `REG_ARB_OWNER_TAG_EN`).

## Operation
- States: IDLE and GAP. Reset state is IDLE.
- Reset values: `q`=0, `ack0`=`ack1`=0, `busy`=0, `last_owner`=0, priority pointer=0 (requester 0 preferred), gap counter=0.
- Eligibility: `reqN` high and `ackN` low in the current cycle. A requester whose ack is high in this cycle is masked at the closing edge, so a req still held during the ack cycle never causes a double load.
- IDLE, with no eligible requester: `q` holds and both acks are 0.
- IDLE, with exactly one eligible requester: that requester wins.
- IDLE, with both eligible: the requester indicated by the pointer wins.
- On a win, at the edge:
  - `q` ← winner's data and `ackWinner` ← 1; the other ack ← 0.
  - Pointer ← other index; `last_owner` ← winner.
  - If `GAP`=0, stay IDLE. Otherwise go to GAP with counter ← `GAP`−1.
- GAP state: requests are ignored and acks are 0 after the first cycle.
  - Counter decrements each edge.
  - When the counter is 0, the next edge returns to IDLE.
  - Total time in GAP is exactly `GAP` cycles.
- The pointer changes only on a win. An uncontested winner still flips the pointer.
- `clear` asserted at any time, including mid-GAP or during an ack cycle: all state goes to reset values immediately. A pending ack is lost and requesters must keep or re-raise `req`.

## Timing
- Load latency: `req` sampled high at edge k, while IDLE and eligible, gives `q` updated and ack high after edge k. This is 1 cycle.
- Ack width is exactly 1 cycle; `ack0` and `ack1` are never high together.
- Back-to-back loads with `GAP`=0 and both requesters held: grants alternate 0,1,0,1 on consecutive edges.
- A single requester held continuously with `GAP`=0 loads every other edge, because of masking during its ack cycle.
- Minimum spacing between loads is `GAP`+1 edges, or 2 edges for the same requester when `GAP`=0.
- `busy` rises after the load edge and falls after the last gap edge.

## Configuration
- `REG_ARB_OWNER_TAG_EN` defined: `last_owner` port and its flop exist. It updates on each load and resets to 0.
- Not defined: the port and flop are absent, and all other behaviour is identical.

## Structure
- Shared package holds:
  - the state encoding constants (`ST_IDLE`, `ST_GAP`);
  - the requester index constants (`REQ0`=0, `REQ1`=1);
  - the gap counter width (4).
- Sub-module `rr_arbiter_2`: combinational two-way round-robin pick from eligibility bits and the pointer, returning one-hot grant.
- Pointer, FSM, counter and data register stay in the top.

## Test plan
- Reset: assert `clear` mid-stream with `q`=0xA → `q`=0, acks=0, `busy`=0 asynchronously, before the next `clk` edge.
- Single request: `req0`=1, `d0`=0x5, `GAP`=0 → `q`=0x5 and `ack0`=1 after the next edge; if `req0` is dropped on ack, no further load.
- Contention: `req0`=`req1`=1 held, `d0`=0x3, `d1`=0xC, pointer=0 → loads 0x3, 0xC, 0x3 on three consecutive edges, with acks alternating.
- Gap: `GAP`=3, both held → a load, then `busy` high for 3 cycles with no ack, then the next load goes to the other requester.
- Held request masking: only `req1` held with `d1`=0x9 and `GAP`=0 → `ack1` on alternate edges, never two consecutive.
- Reset during GAP: `GAP`=5, `clear` pulsed on the second gap cycle → IDLE, pointer=0; with both requesting after release, requester 0 wins first.

Source files
------------

// File: rtl/reg_load_arbiter_pkg.sv
// reg_load_arbiter_pkg: shared state encoding, requester indices and gap counter width
package reg_load_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_GAP = 1'b1} state_e;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
  localparam int CNT_W = 4;
endpackage

// File: rtl/reg_load_arbiter_rr.sv
// rr_arbiter_2: combinational two-way round-robin pick, one-hot grant
module rr_arbiter_2 (
  input  logic [1:0] elig_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);
  // the pointer only breaks ties; a lone eligible requester always wins
  assign grant_o[0] = elig_i[0] & (~elig_i[1] | ~ptr_i);
  assign grant_o[1] = elig_i[1] & (~elig_i[0] | ptr_i);
endmodule

// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter: two-requester round-robin loader for a shared register with optional idle gap.
// Define REG_ARB_OWNER_TAG_EN to add the last_owner port and flop.
module reg_load_arbiter
  import reg_load_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] q,
  output logic             busy
`ifdef REG_ARB_OWNER_TAG_EN
  ,
  output logic             last_owner
`endif
);
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP > 0 ? GAP - 1 : 0);
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ptr_q;
  logic             ack0_q, ack1_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       elig, grant;
  logic             win;
  // a requester being acked this cycle is masked so a held req cannot reload
  assign elig   = {req1 & ~ack1_q, req0 & ~ack0_q};
  assign win    = (state_q == ST_IDLE) & |grant;
  assign data_d = grant[1] ? d1 : d0;
  rr_arbiter_2 u_rr (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .grant_o(grant)
  );
`ifdef REG_ARB_OWNER_TAG_EN
  logic owner_q;
  always_ff @(posedge clk or posedge clear)
    if (clear) owner_q <= REQ0;
    else if (win) owner_q <= grant[1] ? REQ1 : REQ0;
  assign last_owner = owner_q;
`endif
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= REQ0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      if (win) begin
        data_q <= data_d;
        ack0_q <= grant[0];
        ack1_q <= grant[1];
        ptr_q  <= grant[0] ? REQ1 : REQ0;
        if (GAP != 0) begin
          state_q <= ST_GAP;
          cnt_q   <= GAP_M1;
        end
      end else if (state_q == ST_GAP) begin
        if (cnt_q == '0) state_q <= ST_IDLE;
        else cnt_q <= cnt_q - 1'b1;
      end
    end
  end
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign q    = data_q;
  assign busy = (state_q == ST_GAP);
endmodule

// File: tb/tb_reg_load_arbiter.sv
// tb_reg_load_arbiter: directed checks on GAP=0, GAP=3 and GAP=5 instances sharing one stimulus
module tb_reg_load_arbiter;
  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] d0 = '0, d1 = '0;
  logic [3:0] q_g0, q_g3, q_g5;
  logic       a0_g0, a1_g0, b_g0, a0_g3, a1_g3, b_g3, a0_g5, a1_g5, b_g5;
`ifdef REG_ARB_OWNER_TAG_EN
  logic       o_g0, o_g3, o_g5;
`endif
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  reg_load_arbiter #(.WIDTH(4), .GAP(0)) g0 (
    .clk(clk), .clear(clear), .req0(req0), .d0(d0), .req1(req1), .d1(d1),
    .ack0(a0_g0), .ack1(a1_g0), .q(q_g0), .busy(b_g0)
`ifdef REG_ARB_OWNER_TAG_EN
    , .last_owner(o_g0)
`endif
  );
  reg_load_arbiter #(.WIDTH(4), .GAP(3)) g3 (
    .clk(clk), .clear(clear), .req0(req0), .d0(d0), .req1(req1), .d1(d1),
    .ack0(a0_g3), .ack1(a1_g3), .q(q_g3), .busy(b_g3)
`ifdef REG_ARB_OWNER_TAG_EN
    , .last_owner(o_g3)
`endif
  );
  reg_load_arbiter #(.WIDTH(4), .GAP(5)) g5 (
    .clk(clk), .clear(clear), .req0(req0), .d0(d0), .req1(req1), .d1(d1),
    .ack0(a0_g5), .ack1(a1_g5), .q(q_g5), .busy(b_g5)
`ifdef REG_ARB_OWNER_TAG_EN
    , .last_owner(o_g5)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic g0_out(input string tag, input logic [3:0] eq, input logic e0, input logic e1);
    chk({tag, ".q"}, q_g0, eq);
    chk({tag, ".ack0"}, a0_g0, e0);
    chk({tag, ".ack1"}, a1_g0, e1);
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    #1 clear = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    g0_out("rst", 4'h0, 1'b0, 1'b0);
    chk("rst.busy", b_g0, 1'b0);
    clear = 1'b0;
    req0 = 1'b1;
    d0 = 4'hA;
    @(negedge clk);
    g0_out("preclr", 4'hA, 1'b1, 1'b0);
    chk("preclr.busy_g3", b_g3, 1'b1);
    clear = 1'b1;
    #1;
    g0_out("async_clr", 4'h0, 1'b0, 1'b0);
    chk("async_clr.busy_g3", b_g3, 1'b0);
    chk("async_clr.q_g3", q_g3, 4'h0);
    req0 = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    req0 = 1'b1;
    d0 = 4'h5;
    @(negedge clk);
    g0_out("single.e1", 4'h5, 1'b1, 1'b0);
    req0 = 1'b0;
    @(negedge clk);
    g0_out("single.e2", 4'h5, 1'b0, 1'b0);
    @(negedge clk);
    g0_out("single.e3", 4'h5, 1'b0, 1'b0);
    pulse_clear();
    req0 = 1'b1;
    req1 = 1'b1;
    d0 = 4'h3;
    d1 = 4'hC;
    @(negedge clk);
    g0_out("cont.e1", 4'h3, 1'b1, 1'b0);
    chk("gap.e1.q", q_g3, 4'h3);
    chk("gap.e1.ack0", a0_g3, 1'b1);
    chk("gap.e1.busy", b_g3, 1'b1);
    @(negedge clk);
    g0_out("cont.e2", 4'hC, 1'b0, 1'b1);
`ifdef REG_ARB_OWNER_TAG_EN
    chk("cont.e2.owner", o_g0, 1'b1);
`endif
    chk("gap.e2.ack", {a1_g3, a0_g3}, 2'b00);
    chk("gap.e2.busy", b_g3, 1'b1);
    @(negedge clk);
    g0_out("cont.e3", 4'h3, 1'b1, 1'b0);
    chk("gap.e3.ack", {a1_g3, a0_g3}, 2'b00);
    chk("gap.e3.busy", b_g3, 1'b1);
    @(negedge clk);
    chk("gap.e4.ack", {a1_g3, a0_g3}, 2'b00);
    chk("gap.e4.busy", b_g3, 1'b0);
    chk("gap.e4.q", q_g3, 4'h3);
    @(negedge clk);
    chk("gap.e5.q", q_g3, 4'hC);
    chk("gap.e5.ack", {a1_g3, a0_g3}, 2'b10);
    chk("gap.e5.busy", b_g3, 1'b1);
    pulse_clear();
    req0 = 1'b0;
    req1 = 1'b1;
    d1 = 4'h9;
    @(negedge clk);
    g0_out("mask.e1", 4'h9, 1'b0, 1'b1);
    @(negedge clk);
    g0_out("mask.e2", 4'h9, 1'b0, 1'b0);
    @(negedge clk);
    g0_out("mask.e3", 4'h9, 1'b0, 1'b1);
    @(negedge clk);
    g0_out("mask.e4", 4'h9, 1'b0, 1'b0);
    pulse_clear();
    req0 = 1'b1;
    req1 = 1'b1;
    d0 = 4'h3;
    d1 = 4'hC;
    @(negedge clk);
    chk("gclr.e1.q", q_g5, 4'h3);
    chk("gclr.e1.ack", {a1_g5, a0_g5}, 2'b01);
    @(negedge clk);
    chk("gclr.e2.busy", b_g5, 1'b1);
    clear = 1'b1;
    #1;
    chk("gclr.busy", b_g5, 1'b0);
    chk("gclr.q", q_g5, 4'h0);
    clear = 1'b0;
    @(negedge clk);
    chk("gclr.e3.q", q_g5, 4'h3);
    chk("gclr.e3.ack", {a1_g5, a0_g5}, 2'b01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
